// File: rtl/dsp32_port_a_streamer.sv
// Burst streamer between the DSP32 pipeline and port A of the shared dual-port RAM.
// Reads land in a 2-entry skid FIFO so the 1-cycle RAM latency survives stream backpressure.
module dsp32_port_a_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              reseta,
    input  logic              cmd_start,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_ada,
    output logic              ram_cea,
    output logic              ram_ocea,
    output logic              ram_wrea,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] iaddr_reg;
    logic [ADDR_W:0]   issue_cnt_reg;
    logic [ADDR_W:0]   deliver_cnt_reg;
    logic              inflight_reg;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        occ_reg;
    logic              done_reg;
    logic              ocea_reg;

    logic       start_ok;
    logic       pop;
    logic       last_pop;
    logic       rd_issue;
    logic       wr_beat;
    logic       wr_last;
    logic [1:0] occ_next;

    assign start_ok = cmd_start && (cmd_len != '0);
    assign m_valid  = (occ_reg != 2'd0);
    assign m_data   = fifo_mem[rd_ptr_reg];
    assign m_last   = m_valid && (deliver_cnt_reg == CNT_ONE);
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && m_last;
    // Occupancy after this cycle's pop and landing word; a new issue lands one cycle later,
    // so it is safe only while at most one slot is spoken for.
    assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign ram_ocea = ocea_reg;

    always_comb begin
        state_next = state_reg;
        rd_issue   = 1'b0;
        s_ready    = 1'b0;
        wr_beat    = 1'b0;
        wr_last    = 1'b0;
        ram_cea    = 1'b0;
        ram_wrea   = 1'b0;
        ram_ada    = '0;
        ram_dina   = '0;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = cmd_dir ? WR : RD;
            end
            RD: begin
                rd_issue = (issue_cnt_reg != '0) && (occ_next < 2'd2);
                if (rd_issue) begin
                    ram_cea = 1'b1;
                    ram_ada = iaddr_reg;
                end
                if (last_pop) state_next = IDLE;
            end
            WR: begin
                s_ready = (issue_cnt_reg != '0);
                wr_beat = s_valid && s_ready;
                wr_last = wr_beat && (issue_cnt_reg == CNT_ONE);
                if (wr_beat) begin
                    ram_cea  = 1'b1;
                    ram_wrea = 1'b1;
                    ram_ada  = iaddr_reg;
                    ram_dina = s_data;
                end
                if (wr_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reseta) begin
            state_reg       <= IDLE;
            iaddr_reg       <= '0;
            issue_cnt_reg   <= '0;
            deliver_cnt_reg <= '0;
            inflight_reg    <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            occ_reg         <= 2'd0;
            done_reg        <= 1'b0;
            ocea_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ocea_reg     <= 1'b1;
            done_reg     <= last_pop || wr_last;
            inflight_reg <= rd_issue;
            occ_reg      <= occ_next;
            if ((state_reg == IDLE) && start_ok) begin
                iaddr_reg       <= cmd_base;
                issue_cnt_reg   <= cmd_len;
                deliver_cnt_reg <= cmd_len;
            end else begin
                if (rd_issue || wr_beat) begin
                    iaddr_reg     <= iaddr_reg + ADDR_ONE;
                    issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
                end
                if (pop) deliver_cnt_reg <= deliver_cnt_reg - CNT_ONE;
            end
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Skid storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clka) begin
        if (inflight_reg) fifo_mem[wr_ptr_reg] <= ram_douta;
    end
endmodule

// File: tb/tb_dsp32_port_a_streamer.sv
// Bench for dsp32_port_a_streamer: a RAM model on port A, a burst-level reference model
// checked every cycle, directed scenarios with literal expectations, then random bursts.
module tb_dsp32_port_a_streamer;
    logic        clk = 1'b0;
    logic        reseta = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_base = '0;
    logic [8:0]  cmd_len = '0;
    logic        busy, done;
    logic [7:0]  ram_ada;
    logic        ram_cea, ram_ocea, ram_wrea;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta = '0;
    logic        m_valid, m_last;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;

    always #5 clk = ~clk;

    dsp32_port_a_streamer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clka(clk), .reseta(reseta),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .ram_ada(ram_ada), .ram_cea(ram_cea), .ram_ocea(ram_ocea), .ram_wrea(ram_wrea),
        .ram_dina(ram_dina), .ram_douta(ram_douta),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready)
    );

    // Port A RAM with a preload port for the bench.
    logic [31:0] ram_mem [256];
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    always @(posedge clk) begin
        if (load_en) ram_mem[load_addr] <= load_data;
        else if (ram_cea) begin
            if (ram_wrea) ram_mem[ram_ada] <= ram_dina;
            else ram_douta <= ram_mem[ram_ada];
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model state (written only by the monitor).
    logic [31:0] gold [256];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          hs_cyc [$];
    logic [7:0]  addr_log [$];
    logic [7:0]  exp_raddr = '0, exp_waddr = '0;
    int          mode = 0;
    int          rissued = 0, rdelivered = 0, rlen = 0, wremain = 0;
    int          done_cnt = 0, last_done_cyc = 0, acc_cyc = 0;
    bit          exp_busy = 0, done_due = 0, nxt_busy = 0, nxt_done = 0;
    bit          prev_stall = 0, after_rst = 0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (load_en) gold[load_addr] = load_data;
        if (reseta) begin
            exp_busy = 0; done_due = 0; mode = 0; wremain = 0;
            rissued = 0; rdelivered = 0;
            exp_q.delete();
            prev_stall = 0; after_rst = 1;
        end else begin
            nxt_busy = exp_busy;
            nxt_done = 0;
            check("done", done, done_due);
            check("busy", busy, exp_busy);
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (after_rst) begin
                check("rst_flags", 32'({m_valid, m_last, s_ready, ram_cea, ram_wrea, ram_ocea}), 0);
                check("rst_ada", ram_ada, 0);
                check("rst_dina", ram_dina, 0);
                after_rst = 0;
            end else check("ocea", ram_ocea, 1);
            if (mode != 2) check("wrea_not_wr", ram_wrea, 0);
            if (mode == 0) check("cea_idle", ram_cea, 0);
            // read side
            if (ram_cea && !ram_wrea) begin
                check("rd_addr", ram_ada, exp_raddr);
                addr_log.push_back(ram_ada);
                exp_raddr++;
                rissued++;
                check("rd_overissue", rissued <= rlen, 1);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) check("m_valid_unexpected", m_valid, 0);
                else begin
                    check("m_data", m_data, exp_q[0]);
                    check("m_last", m_last, exp_q.size() == 1);
                    if (prev_stall) check("m_stable", m_data, prev_data);
                    if (m_ready) begin
                        got_q.push_back(m_data);
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        rdelivered++;
                        if (exp_q.size() == 0) begin nxt_done = 1; nxt_busy = 0; mode = 0; end
                    end
                end
            end else if (prev_stall) check("m_valid_dropped", m_valid, 1);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            check("outstanding_le2", (rissued - rdelivered) <= 2, 1);
            // write side
            check("s_ready", s_ready, (mode == 2) && (wremain > 0));
            if (s_valid && s_ready) begin
                check("wr_cea", ram_cea, 1);
                check("wr_wrea", ram_wrea, 1);
                check("wr_addr", ram_ada, exp_waddr);
                check("wr_data", ram_dina, s_data);
                gold[exp_waddr] = s_data;
                exp_waddr++;
                wremain--;
                if (wremain == 0) begin nxt_done = 1; nxt_busy = 0; mode = 0; end
            end else if (mode == 2) check("wr_cea_idle", ram_cea, 0);
            // command acceptance
            if (cmd_start && !exp_busy && (cmd_len != 0)) begin
                nxt_busy = 1;
                acc_cyc = cyc;
                if (!cmd_dir) begin
                    mode = 1;
                    exp_q.delete();
                    for (int i = 0; i < int'(cmd_len); i++) exp_q.push_back(gold[8'(int'(cmd_base) + i)]);
                    exp_raddr = cmd_base;
                    rissued = 0; rdelivered = 0; rlen = int'(cmd_len);
                end else begin
                    mode = 2;
                    exp_waddr = cmd_base;
                    wremain = int'(cmd_len);
                end
            end
            done_due = nxt_done;
            exp_busy = nxt_busy;
        end
    end

    // Stimulus
    int          rmode = 0, wmode = 0, ridx = 0, vidx = 0, widx = 0;
    bit          hs_w = 0, last_done = 0;
    logic [5:0]  rpat = 6'b101001;
    logic [3:0]  vpat = 4'b1101;
    logic [31:0] wdata [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    logic [7:0]  t3_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    task automatic tick();
        @(negedge clk);
        hs_w = s_valid && s_ready;
        last_done = done;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        load_en = 1'b0;
        case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 3) != 0);
            default: begin m_ready = rpat[ridx % 6]; ridx++; end
        endcase
        if (hs_w) widx++;
        case (wmode)
            0: s_valid = 1'b0;
            1: begin
                s_valid = (vidx < 4) ? vpat[vidx] : 1'b1;
                vidx++;
                s_data = (widx < 3) ? wdata[widx] : '0;
            end
            default: begin
                s_valid = ($urandom_range(0, 2) != 0);
                s_data = $urandom;
            end
        endcase
    endtask

    task automatic start(input logic dir, input logic [7:0] base, input logic [8:0] len);
        tick();
        cmd_start = 1'b1;
        cmd_dir = dir;
        cmd_base = base;
        cmd_len = len;
    endtask

    task automatic wait_done(input int limit, input bit noise);
        int n = 0;
        forever begin
            tick();
            if (last_done) break;
            n++;
            if (n > limit) begin
                total++; bad++;
                $display("FAIL timeout: no done within %0d cycles", limit);
                break;
            end
            if (noise && busy && ($urandom_range(0, 7) == 0) &&
                (((mode == 1) && (exp_q.size() > 3)) || ((mode == 2) && (wremain > 3)))) begin
                cmd_start = 1'b1;
                cmd_dir = 1'($urandom_range(0, 1));
                cmd_base = 8'($urandom);
                cmd_len = 9'($urandom_range(0, 5));
            end
        end
    endtask

    initial begin
        int g, a, d0, n;
        logic dir;
        logic [8:0] len;
        for (int i = 0; i < 256; i++) begin
            tick();
            load_en = 1'b1;
            load_addr = 8'(i);
            load_data = ((i >= 16) && (i < 20)) ? 32'h11110000 + 32'(i - 16) : $urandom;
        end
        tick();
        tick();
        reseta = 1'b0;

        // 1: plain read, consumer always ready
        rmode = 0;
        g = got_q.size();
        start(1'b0, 8'h10, 9'd4);
        wait_done(50, 0);
        check("t1_count", got_q.size() - g, 4);
        if (got_q.size() == g + 4) begin
            for (int i = 0; i < 4; i++) check("t1_word", got_q[g + i], 32'h11110000 + 32'(i));
            check("t1_back_to_back", hs_cyc[g + 3] - hs_cyc[g], 3);
            check("t1_done_after_last", last_done_cyc - hs_cyc[g + 3], 1);
            check("t1_first_valid_ge2", (hs_cyc[g] - acc_cyc) >= 2, 1);
        end

        // 2: same read, consumer stalls in a fixed pattern
        rmode = 2; ridx = 0;
        g = got_q.size();
        d0 = done_cnt;
        start(1'b0, 8'h10, 9'd4);
        wait_done(80, 0);
        check("t2_count", got_q.size() - g, 4);
        check("t2_done_once", done_cnt - d0, 1);
        if (got_q.size() == g + 4)
            for (int i = 0; i < 4; i++) check("t2_word", got_q[g + i], 32'h11110000 + 32'(i));

        // 3: read wrapping past the top address
        rmode = 0;
        a = addr_log.size();
        start(1'b0, 8'hFE, 9'd4);
        wait_done(50, 0);
        check("t3_issues", addr_log.size() - a, 4);
        if (addr_log.size() == a + 4)
            for (int i = 0; i < 4; i++) check("t3_addr", addr_log[a + i], t3_addr[i]);

        // 4: write with gaps in s_valid
        d0 = done_cnt;
        start(1'b1, 8'h20, 9'd3);
        wmode = 1; vidx = 0; widx = 0;
        wait_done(50, 0);
        wmode = 0;
        check("t4_ram20", ram_mem[8'h20], 32'hAAAA0001);
        check("t4_ram21", ram_mem[8'h21], 32'hBBBB0002);
        check("t4_ram22", ram_mem[8'h22], 32'hCCCC0003);
        check("t4_done_once", done_cnt - d0, 1);
        start(1'b0, 8'h20, 9'd3);
        wait_done(50, 0);

        // 5: zero-length start ignored; start during a busy burst ignored
        d0 = done_cnt;
        start(1'b0, 8'h30, 9'd0);
        repeat (4) tick();
        check("t5_busy_len0", busy, 0);
        check("t5_no_done_len0", done_cnt - d0, 0);
        rmode = 1;
        g = got_q.size();
        start(1'b0, 8'h30, 9'd8);
        repeat (3) tick();
        cmd_start = 1'b1; cmd_dir = 1'b1; cmd_base = 8'h40; cmd_len = 9'd5;
        wait_done(200, 0);
        check("t5_burst_words", got_q.size() - g, 8);
        check("t5_done_once", done_cnt - d0, 1);

        // 6: reset pulse part-way through a read
        rmode = 0;
        g = got_q.size();
        d0 = done_cnt;
        start(1'b0, 8'h10, 9'd4);
        n = 0;
        while ((got_q.size() < g + 2) && (n < 20)) begin tick(); n++; end
        check("t6_two_words", got_q.size() >= g + 2, 1);
        reseta = 1'b1;
        tick();
        reseta = 1'b0;
        repeat (4) tick();
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_idle", busy, 0);
        start(1'b0, 8'hFE, 9'd4);
        wait_done(50, 0);
        check("t6_rerun_done", done_cnt - d0, 1);

        // random bursts with random backpressure and ignored commands
        rmode = 1; wmode = 2;
        for (int k = 0; k < 60; k++) begin
            dir = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(1, 24));
            if ($urandom_range(0, 4) == 0) start(dir, 8'($urandom), 9'd0);
            start(dir, 8'($urandom), len);
            wait_done(3000, 1);
        end
        rmode = 0; wmode = 0;
        repeat (3) tick();
        for (int i = 0; i < 256; i++) check("ram_final", ram_mem[i], gold[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end
endmodule
